// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset release sequencer.
package rst_seq_pkg;

    localparam int DEFAULT_DELAY_W     = 8;
    localparam int DEFAULT_NUM_DOMAINS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RELEASE,
        S_DONE,
        S_WAIT_ACK
    } rst_seq_state_t;

    typedef logic [DEFAULT_DELAY_W-1:0] delay_arr_t [DEFAULT_NUM_DOMAINS];

    function automatic logic is_busy_state(rst_seq_state_t s);
        return (s == S_WAIT) || (s == S_RELEASE) || (s == S_WAIT_ACK);
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle of the reset sequencer; ack_i exists only with RST_SEQ_ACK_EN.
// Handshake: start_i/stop_i are level-sampled every cycle; no valid/ready pairing.
interface rst_seq_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int DELAY_W     = 8
);
    logic                           start_i;
    logic                           stop_i;
    logic [NUM_DOMAINS*DELAY_W-1:0] delay_i;
    logic [NUM_DOMAINS-1:0]         rst_n_o;
    logic                           busy_o;
    logic                           done_o;
`ifdef RST_SEQ_ACK_EN
    logic [NUM_DOMAINS-1:0]         ack_i;

    modport master (output start_i, stop_i, delay_i, ack_i,
                    input  rst_n_o, busy_o, done_o);
    modport slave  (input  start_i, stop_i, delay_i, ack_i,
                    output rst_n_o, busy_o, done_o);
`else
    modport master (output start_i, stop_i, delay_i,
                    input  rst_n_o, busy_o, done_o);
    modport slave  (input  start_i, stop_i, delay_i,
                    output rst_n_o, busy_o, done_o);
`endif
endinterface

// File: rtl/rst_seq_timer.sv
// Shared gap timer: up-counter with synchronous clear, enable and target compare.
module rst_seq_timer #(
    parameter int DELAY_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DELAY_W-1:0] target_i,
    output logic               expired_o
);
    logic [DELAY_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + DELAY_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == target_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: releases domain resets one at a time after programmable gaps.
// Optional per-domain acknowledge wait enabled by defining RST_SEQ_ACK_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEFAULT_NUM_DOMAINS,
    parameter int DELAY_W     = DEFAULT_DELAY_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rst_seq_if.slave       bus,
    output rst_seq_state_t state_o
);
    localparam int             K_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_DOMAINS - 1);

    typedef logic [DELAY_W-1:0] delay_vec_t [NUM_DOMAINS];

    rst_seq_state_t         state_q, state_d;
    logic [K_W-1:0]         k_q, k_d;
    delay_vec_t             delay_q, delay_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timer_clr, timer_en, timer_expired;

    rst_seq_timer #(.DELAY_W(DELAY_W)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .target_i  (delay_q[k_q]),
        .expired_o (timer_expired)
    );

    // RELEASE marks the cycle right after a release: the next gap is already being timed.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        delay_d   = delay_q;
        rst_n_d   = rst_n_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        if (bus.stop_i) begin
            state_d   = S_IDLE;
            k_d       = '0;
            rst_n_d   = '0;
            timer_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_clr = 1'b1;
                    rst_n_d   = '0;
                    if (bus.start_i) begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            delay_d[i] = bus.delay_i[i*DELAY_W +: DELAY_W];
                        end
                        k_d     = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT, S_RELEASE: begin
                    if (timer_expired) begin
                        rst_n_d[k_q] = 1'b1;
`ifdef RST_SEQ_ACK_EN
                        state_d = S_WAIT_ACK;
`else
                        if (k_q == LAST_K) begin
                            state_d = S_DONE;
                        end else begin
                            k_d       = k_q + K_W'(1);
                            timer_clr = 1'b1;
                            state_d   = S_RELEASE;
                        end
`endif
                    end else begin
                        timer_en = 1'b1;
                        state_d  = S_WAIT;
                    end
                end
`ifdef RST_SEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (bus.ack_i[k_q]) begin
                        if (k_q == LAST_K) begin
                            state_d = S_DONE;
                        end else begin
                            k_d       = k_q + K_W'(1);
                            timer_clr = 1'b1;
                            state_d   = S_WAIT;
                        end
                    end
                end
`endif
                S_DONE: begin
                    rst_n_d = '1;
                end
                default: begin
                    state_d = S_IDLE;
                    rst_n_d = '0;
                end
            endcase
        end
        busy_d = is_busy_state(state_d);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            delay_q <= '{default: '0};
            rst_n_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            delay_q <= delay_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rst_n_o = rst_n_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    localparam int ND = 4;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    rst_seq_state_t state;

    rst_seq_if #(.NUM_DOMAINS(ND), .DELAY_W(DW)) bus ();

    rst_seq_ctrl #(.NUM_DOMAINS(ND), .DELAY_W(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          stop;
        logic [ND-1:0] exp_rst_n;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [ND*DW-1:0] pack_delay(delay_arr_t d);
        logic [ND*DW-1:0] r;
        for (int i = 0; i < ND; i++) r[i*DW +: DW] = d[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(string name, logic [ND-1:0] er, logic eb, logic ed);
        n_vec++;
        if (bus.rst_n_o !== er || bus.busy_o !== eb || bus.done_o !== ed) begin
            n_err++;
            $display("FAIL %s: rst_n_o=%b busy_o=%b done_o=%b, expected rst_n_o=%b busy_o=%b done_o=%b",
                     name, bus.rst_n_o, bus.busy_o, bus.done_o, er, eb, ed);
        end
    endtask

    task automatic check_state(string name, rst_seq_state_t es);
        n_vec++;
        if (state !== es) begin
            n_err++;
            $display("FAIL %s: state=%s, expected %s", name, state.name(), es.name());
        end
    endtask

    task automatic add_vec(logic st, logic sp, logic [ND-1:0] r, logic b, logic d);
        vec_t v;
        v.start = st; v.stop = sp; v.exp_rst_n = r; v.exp_busy = b; v.exp_done = d;
        vecs.push_back(v);
    endtask

    delay_arr_t d_main = '{8'd2, 8'd0, 8'd5, 8'd1};
    delay_arr_t d_ones = '{8'd1, 8'd1, 8'd1, 8'd1};

    initial begin
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.delay_i = '0;
`ifdef RST_SEQ_ACK_EN
        bus.ack_i   = '0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        check_outs("reset_outputs", 4'b0000, 1'b0, 1'b0);
        check_state("reset_state", S_IDLE);
        rst = 1'b0;
        tick();
        check_outs("idle_after_reset", 4'b0000, 1'b0, 1'b0);

`ifndef RST_SEQ_ACK_EN
        // Row i is the edge t0+(i-2) relative to the accepted start on row 2.
        add_vec(1, 1, 4'b0000, 0, 0);
        add_vec(0, 0, 4'b0000, 0, 0);
        add_vec(1, 0, 4'b0000, 1, 0);
        add_vec(0, 0, 4'b0000, 1, 0);
        add_vec(0, 0, 4'b0000, 1, 0);
        add_vec(0, 0, 4'b0001, 1, 0);
        add_vec(0, 0, 4'b0011, 1, 0);
        for (int i = 0; i < 5; i++) add_vec(0, 0, 4'b0011, 1, 0);
        add_vec(0, 0, 4'b0111, 1, 0);
        add_vec(0, 0, 4'b0111, 1, 0);
        add_vec(0, 0, 4'b1111, 0, 1);
        add_vec(1, 0, 4'b1111, 0, 1);
        add_vec(1, 0, 4'b1111, 0, 1);
        add_vec(0, 1, 4'b0000, 0, 0);
        add_vec(0, 0, 4'b0000, 0, 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                bus.start_i = vecs[i].start;
                bus.stop_i  = vecs[i].stop;
                bus.delay_i = (pass == 1 && i > 2) ? '1 : pack_delay(d_main);
                tick();
                check_outs($sformatf("table_p%0d_v%0d", pass, i),
                           vecs[i].exp_rst_n, vecs[i].exp_busy, vecs[i].exp_done);
            end
        end
        check_state("table_end_idle", S_IDLE);

        // Stop mid-sequence: domain 2 must never be released.
        bus.delay_i = pack_delay(d_main);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (5) tick();
        check_outs("stop_pre", 4'b0011, 1'b1, 1'b0);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check_outs("stop_edge", 4'b0000, 1'b0, 1'b0);
        check_state("stop_state", S_IDLE);
        repeat (6) tick();
        check_outs("stop_no_release", 4'b0000, 1'b0, 1'b0);

        // Restart with fresh delays; later delay_i changes are ignored.
        bus.delay_i = pack_delay(d_ones);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.delay_i = pack_delay(d_main);
        check_outs("restart_t0", 4'b0000, 1'b1, 1'b0);
        tick(); check_outs("restart_t1", 4'b0000, 1'b1, 1'b0);
        tick(); check_outs("restart_t2", 4'b0001, 1'b1, 1'b0);
        tick(); check_outs("restart_t3", 4'b0001, 1'b1, 1'b0);
        tick(); check_outs("restart_t4", 4'b0011, 1'b1, 1'b0);
        tick(); tick(); check_outs("restart_t6", 4'b0111, 1'b1, 1'b0);
        tick(); check_outs("restart_t7", 4'b0111, 1'b1, 1'b0);
        tick(); check_outs("restart_t8", 4'b1111, 1'b0, 1'b1);
        check_state("restart_done", S_DONE);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check_outs("restart_stop", 4'b0000, 1'b0, 1'b0);

        // Synchronous reset mid-sequence with start_i held high.
        bus.start_i = 1'b1;
        tick();
        repeat (4) tick();
        check_outs("rst_pre", 4'b0011, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_outs("rst_edge", 4'b0000, 1'b0, 1'b0);
        check_state("rst_state", S_IDLE);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_outs($sformatf("rst_hold_%0d", i), 4'b0000, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();
        check_outs("rst_release_start", 4'b0000, 1'b1, 1'b0);
        check_state("rst_release_state", S_WAIT);
        bus.start_i = 1'b0;
        repeat (3) tick();
        check_outs("rst_release_d0", 4'b0001, 1'b1, 1'b0);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check_outs("rst_final_stop", 4'b0000, 1'b0, 1'b0);
`else
        // Acknowledge mode: each release waits for ack_i[k] before the next gap starts.
        bus.delay_i = pack_delay(d_ones);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check_outs("ack_t0", 4'b0000, 1'b1, 1'b0);
        tick(); check_outs("ack_t1", 4'b0000, 1'b1, 1'b0);
        tick(); check_outs("ack_t2", 4'b0001, 1'b1, 1'b0);
        check_state("ack_wait_state", S_WAIT_ACK);
        tick(); tick();
        check_outs("ack_t4", 4'b0001, 1'b1, 1'b0);
        bus.ack_i = 4'b0001;
        tick();
        bus.ack_i = 4'b1111;
        check_state("ack_t5_state", S_WAIT);
        tick(); check_outs("ack_t6", 4'b0001, 1'b1, 1'b0);
        tick(); check_outs("ack_t7", 4'b0011, 1'b1, 1'b0);
        repeat (3) tick();
        check_outs("ack_t10", 4'b0111, 1'b1, 1'b0);
        repeat (3) tick();
        check_outs("ack_t13", 4'b1111, 1'b1, 1'b0);
        tick(); check_outs("ack_t14", 4'b1111, 1'b0, 1'b1);
        check_state("ack_done_state", S_DONE);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.ack_i  = '0;
        check_outs("ack_stop_done", 4'b0000, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick(); tick();
        check_state("ack_wait_again", S_WAIT_ACK);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check_outs("ack_stop_wait", 4'b0000, 1'b0, 1'b0);
        check_state("ack_stop_state", S_IDLE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
